// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported memory between an instruction-fetch port and a
// data load/store port. Data requests win over fetches when both are pending
// in IDLE. Each access is IDLE -> FETCH/DATA -> RESP -> IDLE, so back-to-back
// accesses with a zero-wait memory complete every three cycles. Misaligned
// stores skip the memory and answer directly with dhit + dmisalign.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES cycles without mem_ready. The abort pulses the hit and
// bus_err together and writes 32'h0 into the load register. When the macro is
// undefined the arbiter waits forever and bus_err is always 0.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   iread, iaddr           fetch request and byte address
//   ihit, iload            fetch-complete pulse and fetched word
//   dread, dwrite          load request; store size (00 none/01 b/10 h/11 w)
//   daddr, dstore          data byte address and store data
//   dhit, dload, dmisalign data-complete pulse, loaded word, misalign flag
//   mem_req, mem_wen       memory request and byte strobes (0 = read)
//   mem_addr, mem_wdata    word-aligned address and replicated write data
//   mem_rdata, mem_ready   memory read data and completion strobe
//   bus_err                timeout abort pulse
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iread,
    input  logic [31:0] iaddr,
    output logic        ihit,
    output logic [31:0] iload,
    input  logic        dread,
    input  logic [1:0]  dwrite,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        dmisalign,
    output logic        mem_req,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        DATA  = 2'b10,
        RESP  = 2'b11
    } state_t;

    state_t      state_r;
    logic        store_r;
    logic        data_req_s;
    logic        store_s;
    logic        misalign_s;
    logic [3:0]  strobe_s;
    logic [31:0] wdata_s;
    logic        unused_s;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_r;
`endif

    // Fetch addresses are always treated as word aligned.
    assign unused_s = ^iaddr[1:0];

    function automatic logic [3:0] calc_strobe(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            2'b01:   calc_strobe = 4'b0001 << lsb;
            2'b10:   calc_strobe = lsb[1] ? 4'b1100 : 4'b0011;
            2'b11:   calc_strobe = 4'b1111;
            default: calc_strobe = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b01:   calc_wdata = {4{data[7:0]}};
            2'b10:   calc_wdata = {2{data[15:0]}};
            2'b11:   calc_wdata = data;
            default: calc_wdata = 32'h0000_0000;
        endcase
    endfunction

    // Loads carry no size, so only halfword and word stores can be misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            2'b10:   is_misaligned = lsb[0];
            2'b11:   is_misaligned = (lsb != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    // Decode of the data request presented in IDLE.
    always_comb begin
        data_req_s = dread | (dwrite != 2'b00);
        store_s    = (dwrite != 2'b00);
        strobe_s   = calc_strobe(dwrite, daddr[1:0]);
        wdata_s    = calc_wdata(dwrite, dstore);
        misalign_s = is_misaligned(dwrite, daddr[1:0]);
    end

    // Arbitration FSM; every output is a register written here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            store_r    <= 1'b0;
            mem_req    <= 1'b0;
            mem_wen    <= 4'b0000;
            mem_addr   <= 32'h0000_0000;
            mem_wdata  <= 32'h0000_0000;
            ihit       <= 1'b0;
            iload      <= 32'h0000_0000;
            dhit       <= 1'b0;
            dload      <= 32'h0000_0000;
            dmisalign  <= 1'b0;
            bus_err    <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt_r <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_cnt_r <= '0;
`endif
                    if (data_req_s) begin
                        if (misalign_s) begin
                            // Answer immediately without touching memory.
                            state_r   <= RESP;
                            dhit      <= 1'b1;
                            dmisalign <= 1'b1;
                        end else begin
                            state_r   <= DATA;
                            store_r   <= store_s;
                            mem_req   <= 1'b1;
                            mem_addr  <= {daddr[31:2], 2'b00};
                            mem_wen   <= strobe_s;
                            mem_wdata <= wdata_s;
                        end
                    end else if (iread) begin
                        state_r   <= FETCH;
                        store_r   <= 1'b0;
                        mem_req   <= 1'b1;
                        mem_addr  <= {iaddr[31:2], 2'b00};
                        mem_wen   <= 4'b0000;
                        mem_wdata <= 32'h0000_0000;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    if (mem_ready) begin
                        iload   <= mem_rdata;
                        mem_req <= 1'b0;
                        ihit    <= 1'b1;
                        state_r <= RESP;
                    end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                        if (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            iload   <= 32'h0000_0000;
                            mem_req <= 1'b0;
                            ihit    <= 1'b1;
                            bus_err <= 1'b1;
                            state_r <= RESP;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                        end
`else
                        state_r <= FETCH;
`endif
                    end
                end
                DATA: begin
                    if (mem_ready) begin
                        // Stores keep the previous load value.
                        if (!store_r) begin
                            dload <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        dhit    <= 1'b1;
                        state_r <= RESP;
                    end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                        if (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            dload   <= 32'h0000_0000;
                            mem_req <= 1'b0;
                            dhit    <= 1'b1;
                            bus_err <= 1'b1;
                            state_r <= RESP;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                        end
`else
                        state_r <= DATA;
`endif
                    end
                end
                RESP: begin
                    // One-cycle response; requests are not sampled here.
                    ihit      <= 1'b0;
                    dhit      <= 1'b0;
                    dmisalign <= 1'b0;
                    bus_err   <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
